// File: rtl/interrupt_arbiter.sv
// Nested-priority interrupt arbiter for three latched sources.
// Tracks handlers in service and masks sources at or below the active level.
module interrupt_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] indication,
  input  logic       ie,
  input  logic       ack,
  input  logic       eret,
  output logic       irq,
  output logic [1:0] irq_id,
  output logic [2:0] clear,
  output logic [2:0] in_service,
  output logic [1:0] depth
);

  logic       ack_ok;
  logic [2:0] onehot;
  logic [2:0] ins_nxt;
  logic [2:0] clr_nxt;
  logic [2:0] mask;
  logic [2:0] elig;
  logic       irq_nxt;
  logic [1:0] id_nxt;
  logic [1:0] depth_nxt;

  // eret wins over a coincident ack; the CPU re-samples irq
  always_comb begin
    ack_ok  = ack & irq & ~eret;
    onehot  = 3'b001 << irq_id;
    ins_nxt = in_service;
    clr_nxt = 3'b000;
    if (eret && (in_service != 3'b000)) begin
      if (in_service[2])
        ins_nxt[2] = 1'b0;
      else if (in_service[1])
        ins_nxt[1] = 1'b0;
      else
        ins_nxt[0] = 1'b0;
    end else if (ack_ok) begin
      ins_nxt = in_service | onehot;
      clr_nxt = onehot;
    end
  end

  // only sources strictly above the innermost active level may request
  always_comb begin
    if (ins_nxt[2])
      mask = 3'b000;
    else if (ins_nxt[1])
      mask = 3'b100;
    else if (ins_nxt[0])
      mask = 3'b110;
    else
      mask = 3'b111;
    elig    = indication & mask;
    irq_nxt = ie & (elig != 3'b000);
    if (elig[2])
      id_nxt = 2'd2;
    else if (elig[1])
      id_nxt = 2'd1;
    else if (elig[0])
      id_nxt = 2'd0;
    else
      id_nxt = irq_id;
    depth_nxt = {1'b0, ins_nxt[0]}
              + {1'b0, ins_nxt[1]}
              + {1'b0, ins_nxt[2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq        <= 1'b0;
      irq_id     <= 2'd0;
      clear      <= 3'b000;
      in_service <= 3'b000;
      depth      <= 2'd0;
    end else begin
      irq        <= irq_nxt;
      irq_id     <= id_nxt;
      clear      <= clr_nxt;
      in_service <= ins_nxt;
      depth      <= depth_nxt;
    end
  end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Randomized scoreboard bench for interrupt_arbiter.
// Reference model keeps handlers as a nesting stack of source numbers.
module tb_interrupt_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] indication;
  logic       ie;
  logic       ack;
  logic       eret;
  logic       irq;
  logic [1:0] irq_id;
  logic [2:0] clear;
  logic [2:0] in_service;
  logic [1:0] depth;

  interrupt_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .indication (indication),
    .ie         (ie),
    .ack        (ack),
    .eret       (eret),
    .irq        (irq),
    .irq_id     (irq_id),
    .clear      (clear),
    .in_service (in_service),
    .depth      (depth)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       irq;
    bit [1:0] id;
    bit [2:0] clr;
    bit [2:0] ins;
    bit [1:0] dep;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 0;

  // model state
  int   stk[$];
  bit   m_irq = 0;
  int   m_id = 0;

  function automatic exp_t model_step(bit r, bit [2:0] ind,
                                      bit en, bit a, bit e);
    exp_t x;
    int   level;
    int   best;
    bit   acc;
    x.clr = 3'b000;
    if (r) begin
      stk.delete();
      m_irq = 0;
      m_id  = 0;
    end else begin
      acc = a && m_irq && !e;
      if (e && stk.size() > 0)
        void'(stk.pop_back());
      else if (acc) begin
        stk.push_back(m_id);
        x.clr = 3'(1 << m_id);
      end
      level = -1;
      foreach (stk[k])
        if (stk[k] > level) level = stk[k];
      best = -1;
      for (int i = 2; i > level; i--)
        if (best < 0 && ind[i]) best = i;
      m_irq = en && (best >= 0);
      if (best >= 0) m_id = best;
    end
    x.irq = m_irq;
    x.id  = 2'(m_id);
    x.ins = 3'b000;
    foreach (stk[k])
      x.ins[stk[k]] = 1'b1;
    x.dep = 2'(stk.size());
    return x;
  endfunction

  task automatic drive(bit r, bit [2:0] ind, bit en, bit a, bit e);
    @(negedge clk);
    rst        = r;
    indication = ind;
    ie         = en;
    ack        = a;
    eret       = e;
    sb.push_back(model_step(r, ind, en, a, e));
  endtask

  // monitor: outputs are registered, so every edge presents a result
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        vectors++;
        if (irq !== x.irq) begin
          miscompares++;
          $display("FAIL irq: got %b want %b @%0t", irq, x.irq, $time);
        end
        if (irq_id !== x.id) begin
          miscompares++;
          $display("FAIL irq_id: got %0d want %0d @%0t", irq_id, x.id, $time);
        end
        if (clear !== x.clr) begin
          miscompares++;
          $display("FAIL clear: got %b want %b @%0t", clear, x.clr, $time);
        end
        if (in_service !== x.ins) begin
          miscompares++;
          $display("FAIL in_service: got %b want %b @%0t",
                   in_service, x.ins, $time);
        end
        if (depth !== x.dep) begin
          miscompares++;
          $display("FAIL depth: got %0d want %0d @%0t", depth, x.dep, $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; indication = 3'b000; ie = 1'b0; ack = 1'b0; eret = 1'b0;
    drive(1, 3'b000, 0, 0, 0);
    drive(1, 3'b111, 1, 1, 1);
    // single request, ack, eret
    drive(0, 3'b010, 1, 0, 0);
    drive(0, 3'b010, 1, 0, 0);
    drive(0, 3'b010, 1, 1, 0);
    drive(0, 3'b000, 1, 0, 0);
    drive(0, 3'b000, 1, 0, 1);
    // priority and masking
    drive(0, 3'b101, 1, 0, 0);
    drive(0, 3'b101, 1, 1, 0);
    drive(0, 3'b001, 1, 0, 0);
    drive(0, 3'b001, 1, 0, 1);
    // preemption to depth 3, then collisions
    drive(0, 3'b001, 1, 1, 0);
    drive(0, 3'b010, 1, 0, 0);
    drive(0, 3'b010, 1, 1, 0);
    drive(0, 3'b100, 1, 0, 0);
    drive(0, 3'b100, 1, 1, 0);
    drive(0, 3'b111, 1, 1, 0);
    drive(0, 3'b111, 1, 1, 1);
    drive(0, 3'b111, 0, 1, 1);
    drive(0, 3'b111, 0, 1, 1);
    drive(0, 3'b111, 0, 0, 1);
    drive(0, 3'b111, 1, 0, 0);
    drive(0, 3'b111, 1, 1, 0);
    drive(1, 3'b111, 1, 1, 0);
    drive(0, 3'b000, 1, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom % 97) == 0,
            3'($urandom),
            ($urandom % 8) != 0,
            ($urandom % 3) == 0,
            ($urandom % 5) == 0);
    end
    drive(0, 3'b000, 1, 0, 0);
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    if (!done) begin
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/interrupt_arbiter.md
INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port indication, input, 3; latched request level per source, from InterruptSampler instances; bit 2 is highest priority, bit 0 lowest.
REQ-004 SHALL have port ie, input, 1; global interrupt enable from the CPU.
REQ-005 SHALL have port ack, input, 1; one-cycle CPU pulse meaning the CPU has entered the handler for irq_id.
REQ-006 SHALL have port eret, input, 1; one-cycle CPU pulse meaning the CPU has returned from the innermost handler.
REQ-007 SHALL have port irq, output, 1; registered interrupt request to the CPU.
REQ-008 SHALL have port irq_id, output, 2; registered source number (0..2) of the current request; meaningful only while irq=1.
REQ-009 SHALL have port clear, output, 3; registered one-cycle one-hot pulses to each sampler's rst.
REQ-010 SHALL have port in_service, output, 3; registered mask of handlers entered and not yet returned.
REQ-011 SHALL have port depth, output, 2; registered nesting depth, equal to the popcount of in_service.

Function
REQ-012 SHALL define level = index of the highest set in_service bit, or -1 when in_service=0.
REQ-013 SHALL define eligible = indication bits with index > level.
REQ-014 SHALL compute next irq = ie AND (eligible != 0).
REQ-015 SHALL compute next irq_id = highest eligible index.
REQ-016 SHALL hold irq_id at its previous value when nothing is eligible.
REQ-017 SHALL compute next irq and next irq_id from the next-cycle in_service and the current indication and ie.
REQ-018 SHALL accept ack only when irq=1 AND eret=0; otherwise ack is ignored.
REQ-019 On an accepted ack, SHALL set in_service[irq_id] and increment depth at that edge.
REQ-020 On an accepted ack, SHALL assert clear[irq_id] for exactly the next cycle; clear is 0 in all other cycles.
REQ-021 On eret with in_service != 0, SHALL clear the highest set in_service bit and decrement depth.
REQ-022 SHALL ignore eret when in_service=0; no state change and no error.
REQ-023 When ack and eret occur in the same cycle, SHALL process only eret and drop ack; the CPU re-samples irq.
REQ-024 SHALL keep a source masked while its in_service bit is set, even if indication is still high from a new edge after clear; it re-requests after the matching eret.
REQ-025 SHALL allow a higher-priority source to preempt, so nesting can reach depth 3.
REQ-026 SHALL never allow a lower-priority or equal-priority source to preempt.
REQ-027 SHALL gate only irq with ie=0; ack is then ignored because irq=0, while eret and in_service still operate.
REQ-028 SHALL contain no combinational path from any input to any output.

Reset
REQ-029 While rst=1 at a clock edge, SHALL set irq=0, irq_id=0, clear=3'b000, in_service=3'b000, and depth=0.
REQ-030 SHALL ignore ack and eret in a cycle where rst=1.
REQ-031 SHALL allow reset mid-service; it abandons all nesting without pulsing clear, and samplers are cleared by the shared system reset.
REQ-032 SHALL resume normal evaluation on the first edge with rst=0; irq can rise one cycle after reset release if indication and ie are already high.

Verification
REQ-033 Single request: ie=1, indication=3'b010 at edge N -> irq=1, irq_id=1 after edge N; ack at N+2 -> after N+2, in_service=3'b010, depth=1, irq=0; clear=3'b010 for exactly one cycle; eret later -> in_service=0, depth=0.
REQ-034 Priority: indication=3'b101 with in_service=0 -> irq_id=2; after ack, clear=3'b100, and irq stays 0 while source 0 is masked, since 0 < level 2; after eret -> irq=1, irq_id=0.
REQ-035 Preemption: in service for source 0 (depth=1), then indication[2] rises -> irq=1, irq_id=2; ack -> in_service=3'b101, depth=2; first eret -> in_service=3'b001; second eret -> 3'b000.
REQ-036 Collisions: ack with irq=0 -> no change; ack and eret in the same cycle with in_service=3'b001 and irq=1 for source 2 -> in_service=3'b000, clear=3'b000, irq still 1 with irq_id=2.
REQ-037 Enable and eret: ie=0 with indication=3'b111 -> irq stays 0; raising ie -> irq=1, irq_id=2 one cycle later; eret with in_service=0 -> all outputs unchanged.
REQ-038 Reset mid-operation: depth=2, irq=1, then rst=1 for one edge -> all outputs 0, with no clear pulse.
